uart_sort_framer: RTL and testbench
===================================

# uart_sort_framer

Framed, length-variable request/response controller between the byte-level UART (`uart_rx`/`uart_tx`) and the `sort_top` bitonic sorter. It parses checksummed request frames carrying 1..DEPTH words and a mode byte, pads the unused sorter slots, and runs the sorter. It then returns a checksummed response frame in ascending or descending order. Protocol errors and inter-byte timeouts produce an error response.

## Interface
- `WIDTH`, 32: word width in bits; multiple of 8. `BPW = WIDTH/8` is derived.
- `DEPTH`, 8: sorter slots; power of two, 2..128.
- `TIMEOUT_CYC`, 1_000_000: maximum idle clocks between bytes inside a frame.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_byte` in 8: received byte.
- `rx_valid` in 1: 1-cycle strobe; `rx_byte` is valid.
- `tx_byte` out 8: byte to transmit; held stable from `tx_valid` until the next `tx_valid`.
- `tx_valid` out 1: 1-cycle start strobe to `uart_tx`.
- `tx_busy` in 1: the UART transmitter is busy.
- `sort_start` out 1: 1-cycle strobe to `sort_top`; `unsorted` is stable from this cycle until `sort_done`.
- `unsorted` out DEPTH×WIDTH: unpacked array, element 0 first.
- `sorted` in DEPTH×WIDTH: ascending sorter result.
- `sort_done` in 1: 1-cycle strobe; `sorted` is valid.
- `busy` out 1: high outside IDLE.
- `rx_drop` out 1: sticky; set when a byte arrives while in SORT or TX; cleared only by reset.

## Operation
Request frame:
- `0xA5`, CMD, LEN, LEN×BPW data bytes (big-endian, MSB byte first), CSUM.
- CMD bit0 selects the mode: 0 = ascending, 1 = descending. Other CMD bits are ignored but included in the checksum.
- CSUM = XOR of CMD, LEN and all data bytes.

Response frame:
- `0x5A`, STAT, RLEN, RLEN×BPW data bytes, RCSUM.
- RCSUM = XOR of STAT, RLEN and all data bytes.
- STAT values: 0x00 ok, 0x01 bad length, 0x02 bad checksum, 0x03 timeout.
- Every error response has RLEN = 0.

States: IDLE, CMD, LEN, DATA, CSUM, SORT, TX.
- IDLE: bytes other than `0xA5` are discarded silently. `0xA5` → CMD.
- CMD → LEN.
- LEN:
  - LEN = 0 or LEN > DEPTH → TX with STAT 0x01. The rest of the incoming frame is not consumed; its bytes fall into `rx_drop` or are discarded in IDLE.
  - Otherwise → DATA.
- DATA: a byte counter runs 0..LEN×BPW−1 and shifts each byte into word slot `cnt/BPW`. On the last byte → CSUM.
- CSUM:
  - Mismatch → TX with STAT 0x02.
  - Match → fill slots LEN..DEPTH−1 with the pad value, then → SORT.
  - Pad value: all-ones for ascending, all-zeros for descending.
- SORT: pulse `sort_start`, wait for `sort_done`, latch `sorted` into the result register, then → TX with STAT 0x00.
- TX output order:
  - Ascending: `sorted[0..LEN−1]`.
  - Descending: `sorted[DEPTH−1]` down to `sorted[DEPTH−LEN]`.
  - Padding therefore never appears in the output.
- After the last byte is accepted by the UART (`tx_busy` low after RCSUM) → IDLE.
- Timeout: in CMD, LEN, DATA or CSUM, TIMEOUT_CYC clocks without `rx_valid` → TX with STAT 0x03. The timeout counter reloads on every `rx_valid`.

## Timing
- Reset: asynchronous assert, synchronous deassert. While in reset:
  - all outputs are 0, `unsorted` is all 0, the state is IDLE;
  - counters and the checksum accumulator are cleared;
  - `rx_drop` is cleared.
- Reset mid-operation aborts immediately. No partial response continues; the UART may finish the byte it is currently shifting.
- `sort_start` asserts the cycle after the cycle in which the matching CSUM byte is sampled.
- First `tx_valid` timing:
  - ok response: the cycle after `sort_done` is sampled;
  - error response: the cycle after the error is detected.
- TX handshake:
  - `tx_valid` is issued only when `tx_busy` = 0.
  - For the cycle after `tx_valid`, `tx_busy` is ignored. This covers the UART's 1-cycle busy latency.
  - The next byte is then held until `tx_busy` = 0.
- `rx_valid` in the same cycle as a timeout expiry: the byte wins and the timeout is cancelled.
- `sort_done` arriving outside SORT is ignored.

## Structure
- Shared package `uart_sort_pkg` holds:
  - `REQ_HDR` (0xA5) and `RSP_HDR` (0x5A);
  - the STAT codes;
  - the framer state enum.
- Sub-module `uart_frame_tx` is the response serialiser. It takes header, status, length, word array, and a start strobe. It owns the `tx_valid`/`tx_busy` handshake and the RCSUM computation.

## Test plan
- Ascending, LEN = 8, words 8..1: sort starts once; response is `5A 00 08`, words 1..8, then RCSUM.
- Descending, LEN = 3, words {5, 0x10, 2}: slots 3..7 are padded with 0; response data is 0x10, 5, 2.
- LEN = 9 with DEPTH = 8: response is `5A 01 00 01`; `sort_start` never pulses.
- Valid frame with CSUM flipped: response is `5A 02 00 02`.
- Stall after 2 data bytes for TIMEOUT_CYC (set to 100 in the bench): response is `5A 03 00 03`, then back in IDLE.
- Assert `rst_n` low mid-response: `tx_valid`, `busy` and `rx_drop` go to 0 immediately. A following valid frame then gets a correct response.

Source files
------------

// File: rtl/uart_sort_pkg.sv
// Shared constants, status codes and framer states for the UART sort framer.
package uart_sort_pkg;
  localparam logic [7:0] REQ_HDR = 8'hA5;
  localparam logic [7:0] RSP_HDR = 8'h5A;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BADLEN  = 8'h01;
  localparam logic [7:0] STAT_BADCSUM = 8'h02;
  localparam logic [7:0] STAT_TMO     = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_LEN, ST_DATA, ST_CSUM, ST_SORT, ST_TX
  } fr_state_e;
endpackage

// File: rtl/uart_sort_framer_if.sv
// Byte UART and sorter connections of the framer, bundled as one interface.
interface uart_sort_framer_if #(parameter int WIDTH = 32, parameter int DEPTH = 8);
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic [7:0]       tx_byte;
  logic             tx_valid;
  logic             tx_busy;
  logic             sort_start;
  logic [WIDTH-1:0] unsorted [DEPTH];
  logic [WIDTH-1:0] sorted   [DEPTH];
  logic             sort_done;

  modport master (input rx_byte, rx_valid, tx_busy, sorted, sort_done,
                  output tx_byte, tx_valid, sort_start, unsorted);
  modport slave  (output rx_byte, rx_valid, tx_busy, sorted, sort_done,
                  input tx_byte, tx_valid, sort_start, unsorted);
endinterface

// File: rtl/uart_sort_framer_tx.sv
// Response serialiser: header, status, length, words MSB-first, XOR checksum.
module uart_frame_tx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [7:0]       hdr_i,
  input  logic [7:0]       stat_i,
  input  logic [7:0]       len_i,
  input  logic [WIDTH-1:0] words_i [DEPTH],
  output logic [7:0]       tx_byte_o,
  output logic             tx_valid_o,
  input  logic             tx_busy_i,
  output logic             done_o
);
  localparam int BPW = WIDTH / 8;
  localparam int WW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic          act_q, guard_q, tx_valid_q;
  logic [7:0]    tx_byte_q, stat_q, len_q, csum_q, cur_byte;
  logic [15:0]   idx_q, total, last_idx;
  logic [WW-1:0] wcnt_q;
  logic [BW-1:0] bcnt_q;
  logic [WIDTH-1:0] word_sh;
  logic          can, send;

  assign total    = 16'd4 + 16'(len_q) * 16'(BPW);
  assign last_idx = total - 16'd1;
  // busy is masked for two cycles after a strobe to cover the UART's flag latency
  assign can      = !tx_busy_i && !tx_valid_q && !guard_q;
  assign send     = (start_i || (act_q && idx_q != total)) && can;
  assign done_o   = act_q && !start_i && idx_q == total && can;
  assign tx_byte_o  = tx_byte_q;
  assign tx_valid_o = tx_valid_q;

  always_comb begin
    word_sh  = words_i[wcnt_q] << (8 * bcnt_q);
    cur_byte = csum_q;
    if (idx_q == 16'd0)      cur_byte = hdr_i;
    else if (idx_q == 16'd1) cur_byte = stat_q;
    else if (idx_q == 16'd2) cur_byte = len_q;
    else if (idx_q < last_idx) cur_byte = word_sh[WIDTH-1 -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0; guard_q <= 1'b0; tx_valid_q <= 1'b0; tx_byte_q <= '0;
      stat_q <= '0; len_q <= '0; csum_q <= '0; idx_q <= '0; wcnt_q <= '0; bcnt_q <= '0;
    end else begin
      guard_q    <= tx_valid_q;
      tx_valid_q <= send;
      if (start_i) begin
        act_q <= 1'b1; stat_q <= stat_i; len_q <= len_i;
        csum_q <= '0; idx_q <= '0; wcnt_q <= '0; bcnt_q <= '0;
      end
      if (send) begin
        tx_byte_q <= cur_byte;
        idx_q     <= idx_q + 16'd1;
        if (!start_i && idx_q >= 16'd1 && idx_q < last_idx) csum_q <= csum_q ^ cur_byte;
        if (!start_i && idx_q >= 16'd3 && idx_q < last_idx) begin
          if (bcnt_q == BW'(BPW - 1)) begin
            bcnt_q <= '0;
            wcnt_q <= wcnt_q + WW'(1);
          end else begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
      end
      if (done_o) begin
        act_q <= 1'b0;
        idx_q <= '0;
      end
    end
  end
endmodule

// File: rtl/uart_sort_framer.sv
// Request parser and sort sequencer; hands responses to uart_frame_tx.
module uart_sort_framer
  import uart_sort_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_sort_framer_if.master bus,
  output logic               busy,
  output logic               rx_drop
);
  localparam int BPW = WIDTH / 8;
  localparam int WW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  fr_state_e        state_q, state_d;
  logic             mode_q, mode_d, drop_q, drop_d, ss_q, ss_d;
  logic [7:0]       len_q, len_d, csum_q, csum_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WW-1:0]    wslot_q, wslot_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] uns_q [DEPTH];
  logic [WIDTH-1:0] uns_d [DEPTH];
  logic [WIDTH-1:0] res_q [DEPTH];
  logic [WIDTH-1:0] res_d [DEPTH];
  logic [WIDTH-1:0] ord_w [DEPTH];
  logic [WIDTH+7:0] shv;
  logic             in_frame, tmo_exp, tx_start, tx_done;
  logic [7:0]       tx_stat, tx_len;

  assign busy           = (state_q != ST_IDLE);
  assign rx_drop        = drop_q;
  assign bus.sort_start = ss_q;
  assign bus.unsorted   = uns_q;

  // Descending output reads the ascending result from the top slot down.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_w[k] = mode_q ? res_q[DEPTH-1-k] : res_q[k];
  end

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign tmo_exp  = in_frame && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q; mode_d = mode_q; drop_d = drop_q; ss_d = 1'b0;
    len_d = len_q; csum_d = csum_q; cnt_d = cnt_q; wslot_d = wslot_q; bcnt_d = bcnt_q;
    tmo_d = tmo_q; uns_d = uns_q; res_d = res_q; shv = '0;
    tx_start = 1'b0; tx_stat = STAT_OK; tx_len = 8'd0;
    if (in_frame) tmo_d = bus.rx_valid ? '0 : tmo_q + TW'(1);
    if (bus.rx_valid && (state_q == ST_SORT || state_q == ST_TX)) drop_d = 1'b1;
    case (state_q)
      ST_IDLE: if (bus.rx_valid && bus.rx_byte == REQ_HDR) begin
        state_d = ST_CMD; tmo_d = '0; cnt_d = '0; wslot_d = '0; bcnt_d = '0;
      end
      ST_CMD: if (bus.rx_valid) begin
        mode_d = bus.rx_byte[0]; csum_d = bus.rx_byte; state_d = ST_LEN;
      end
      ST_LEN: if (bus.rx_valid) begin
        csum_d = csum_q ^ bus.rx_byte;
        len_d  = bus.rx_byte;
        if (bus.rx_byte == 8'd0 || bus.rx_byte > 8'(DEPTH)) begin
          tx_start = 1'b1; tx_stat = STAT_BADLEN; state_d = ST_TX;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (bus.rx_valid) begin
        csum_d = csum_q ^ bus.rx_byte;
        shv = {uns_q[wslot_q], bus.rx_byte};
        uns_d[wslot_q] = shv[WIDTH-1:0];
        cnt_d = cnt_q + 16'd1;
        if (bcnt_q == BW'(BPW - 1)) begin
          bcnt_d = '0; wslot_d = wslot_q + WW'(1);
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
        if (cnt_q == 16'(len_q) * 16'(BPW) - 16'd1) state_d = ST_CSUM;
      end
      ST_CSUM: if (bus.rx_valid) begin
        if (bus.rx_byte != csum_q) begin
          tx_start = 1'b1; tx_stat = STAT_BADCSUM; state_d = ST_TX;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (i >= int'(len_q)) uns_d[i] = mode_q ? '0 : '1;
          ss_d = 1'b1; state_d = ST_SORT;
        end
      end
      ST_SORT: if (bus.sort_done) begin
        res_d = bus.sorted; tx_start = 1'b1; tx_len = len_q; state_d = ST_TX;
      end
      ST_TX: if (tx_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (tmo_exp) begin
      tx_start = 1'b1; tx_stat = STAT_TMO; tx_len = 8'd0; state_d = ST_TX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; mode_q <= 1'b0; drop_q <= 1'b0; ss_q <= 1'b0;
      len_q <= '0; csum_q <= '0; cnt_q <= '0; wslot_q <= '0; bcnt_q <= '0; tmo_q <= '0;
      uns_q <= '{default: '0}; res_q <= '{default: '0};
    end else begin
      state_q <= state_d; mode_q <= mode_d; drop_q <= drop_d; ss_q <= ss_d;
      len_q <= len_d; csum_q <= csum_d; cnt_q <= cnt_d; wslot_q <= wslot_d; bcnt_q <= bcnt_d;
      tmo_q <= tmo_d; uns_q <= uns_d; res_q <= res_d;
    end
  end

  uart_frame_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .start_i(tx_start), .hdr_i(RSP_HDR), .stat_i(tx_stat),
    .len_i(tx_len), .words_i(ord_w), .tx_byte_o(bus.tx_byte), .tx_valid_o(bus.tx_valid),
    .tx_busy_i(bus.tx_busy), .done_o(tx_done)
  );
endmodule

// File: tb/tb_uart_sort_framer.sv
// Directed bench for uart_sort_framer with behavioural UART transmitter and sorter.
module tb_uart_sort_framer;
  import uart_sort_pkg::*;
  localparam int W = 32, D = 8, TMO = 100;

  logic clk = 1'b0, rst_n = 1'b0;
  logic busy, rx_drop;
  always #5 clk = ~clk;

  uart_sort_framer_if #(.WIDTH(W), .DEPTH(D)) bus();
  uart_sort_framer #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .rx_drop(rx_drop));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // UART transmitter: busy rises one cycle after the strobe and lasts 4 cycles
  logic [7:0] rxq[$];
  int viol = 0, bc = 0;
  logic pend = 1'b0;
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_valid) begin
        if (bus.tx_busy) viol++;
        rxq.push_back(bus.tx_byte);
        pend = 1'b1;
      end else if (pend) begin
        pend = 1'b0; bus.tx_busy = 1'b1; bc = 4;
      end else if (bc > 0) begin
        bc--;
        if (bc == 0) bus.tx_busy = 1'b0;
      end
    end
  end

  // Sorter: ascending result four cycles after start
  int n_sort = 0;
  logic [W-1:0] seen [D];
  logic [W-1:0] cap  [D];
  initial begin
    logic [W-1:0] t;
    bus.sort_done = 1'b0;
    for (int i = 0; i < D; i++) bus.sorted[i] = '0;
    forever begin
      @(negedge clk);
      if (bus.sort_start) begin
        n_sort++;
        for (int i = 0; i < D; i++) begin seen[i] = bus.unsorted[i]; cap[i] = bus.unsorted[i]; end
        for (int i = 0; i < D; i++)
          for (int j = 0; j < D - 1 - i; j++)
            if (cap[j] > cap[j+1]) begin t = cap[j]; cap[j] = cap[j+1]; cap[j+1] = t; end
        repeat (4) @(negedge clk);
        for (int i = 0; i < D; i++) bus.sorted[i] = cap[i];
        bus.sort_done = 1'b1;
        @(negedge clk);
        bus.sort_done = 1'b0;
        chk("rsp_first_valid", 32'(bus.tx_valid), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] wv [16];
  logic [7:0]  expq[$];

  task automatic gap(); repeat (2) @(negedge clk); endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte = b; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] len, input int nw,
                       input logic [7:0] flip);
    logic [7:0] cs, b;
    logic [31:0] w;
    cs = cmd ^ len;
    send(REQ_HDR); gap(); send(cmd); gap(); send(len); gap();
    for (int i = 0; i < nw; i++) begin
      w = wv[i];
      for (int k = 0; k < 4; k++) begin
        b = w[31-8*k -: 8]; cs = cs ^ b; send(b); gap();
      end
    end
    send(cs ^ flip);
  endtask

  task automatic check_rsp(input string tag);
    int t;
    t = 0;
    while (rxq.size() < expq.size() && t < 5000) begin @(negedge clk); t++; end
    chk({tag, "_len"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < rxq.size()) ? {24'h0, rxq[i]} : 32'hDEAD,
          {24'h0, expq[i]});
    t = 0;
    while (busy && t < 2000) begin @(negedge clk); t++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    rxq.delete(); expq.delete();
  endtask

  task automatic set_desc();
    wv[0] = 32'h5; wv[1] = 32'h10; wv[2] = 32'h2;
    expq = {8'h5A, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h02, 8'h14};
  endtask

  initial begin
    int n0, t;
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
    chk("rst_sort_start", 32'(bus.sort_start), 32'd0);
    chk("rst_unsorted0", bus.unsorted[0], 32'd0);
    chk("rst_unsorted7", bus.unsorted[7], 32'd0);
    rst_n = 1'b1;
    gap();

    // stray byte in IDLE is ignored
    send(8'h33); gap();
    chk("idle_discard", 32'(busy), 32'd0);

    // ascending, LEN=8, words 8..1
    for (int i = 0; i < 8; i++) wv[i] = 32'(8 - i);
    frame(8'h00, 8'd8, 8, 8'h00);
    chk("asc_sort_start", 32'(bus.sort_start), 32'd1);
    expq = {8'h5A, 8'h00, 8'h08};
    for (int i = 1; i <= 8; i++) begin
      expq.push_back(8'h00); expq.push_back(8'h00); expq.push_back(8'h00); expq.push_back(8'(i));
    end
    expq.push_back(8'h00);
    check_rsp("asc");
    chk("asc_sort_count", 32'(n_sort), 32'd1);

    // descending, LEN=3, padded with zeros
    set_desc();
    frame(8'h01, 8'd3, 3, 8'h00);
    check_rsp("desc");
    chk("desc_slot0", seen[0], 32'h5);
    chk("desc_slot1", seen[1], 32'h10);
    chk("desc_slot2", seen[2], 32'h2);
    for (int i = 3; i < D; i++) chk($sformatf("desc_pad%0d", i), seen[i], 32'h0);

    // LEN beyond DEPTH: immediate error, no sort, trailing byte dropped
    n0 = n_sort;
    send(REQ_HDR); gap(); send(8'h00); gap(); send(8'd9);
    chk("badlen_first_valid", 32'(bus.tx_valid), 32'd1);
    gap(); send(8'h77);
    chk("badlen_rx_drop", 32'(rx_drop), 32'd1);
    expq = {8'h5A, 8'h01, 8'h00, 8'h01};
    check_rsp("badlen");
    chk("badlen_no_sort", 32'(n_sort), 32'(n0));

    // checksum mismatch
    wv[0] = 32'h1234_5678;
    frame(8'h00, 8'd1, 1, 8'hFF);
    expq = {8'h5A, 8'h02, 8'h00, 8'h02};
    check_rsp("badcsum");
    chk("badcsum_no_sort", 32'(n_sort), 32'(n0));

    // inter-byte timeout after two data bytes
    send(REQ_HDR); gap(); send(8'h00); gap(); send(8'd1); gap();
    send(8'h00); gap(); send(8'h00);
    repeat (50) @(negedge clk);
    chk("tmo_still_busy", 32'(busy), 32'd1);
    chk("tmo_no_rsp_yet", 32'(rxq.size()), 32'd0);
    expq = {8'h5A, 8'h03, 8'h00, 8'h03};
    check_rsp("tmo");

    // reset in the middle of a response
    for (int i = 0; i < 8; i++) wv[i] = 32'(8 - i);
    frame(8'h00, 8'd8, 8, 8'h00);
    t = 0;
    while (rxq.size() < 3 && t < 2000) begin @(negedge clk); t++; end
    chk("mid_rsp_reached", 32'(rxq.size() >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rx_drop", 32'(rx_drop), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while ((bus.tx_busy || pend) && t < 100) begin @(negedge clk); t++; end
    rxq.delete();
    gap();
    set_desc();
    frame(8'h01, 8'd3, 3, 8'h00);
    check_rsp("post_rst");
    chk("post_rst_drop", 32'(rx_drop), 32'd0);
    chk("tx_handshake", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
